// File: rtl/alu_shift_pkg.sv
// Shared shift-unit definitions: FSM encoding, direction codes, default widths.
package alu_shift_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SHW_DEF   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/shift_step_1bit.sv
// Purpose: combinational one-position shift, left or right, with a caller-supplied fill bit.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller owns all sequencing.
module shift_step_1bit
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  logic             dir,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    // Right path is bit-identical to the logical right-shift stage when fill is 0.
    always_comb begin
        if (dir == DIR_LEFT) begin
            shifted = {value[WIDTH-2:0], fill};
        end else begin
            shifted = {fill, value[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/iter_shift_unit_32bit.sv
// Purpose: iterative shifter, one bit per clock for SHAMT cycles; ARITH_SHIFT_EN adds arithmetic right shift.
// Latency: start sampled at an edge, out_valid rises SHAMT edges later (immediately after it when SHAMT=0).
// Backpressure: Result and out_valid hold in DONE until out_ready; start is ignored while busy.
module iter_shift_unit_32bit
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   SHAMT,
    input  logic             DIR,
`ifdef ARITH_SHIFT_EN
    input  logic             ARITH,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] Result,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [SHW-1:0] CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             fill;
    logic [WIDTH-1:0] step_out;

`ifdef ARITH_SHIFT_EN
    logic arith_q, arith_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arith_q <= 1'b0;
        end else begin
            arith_q <= arith_d;
        end
    end

    always_comb begin
        arith_d = arith_q;
        if (state_q == IDLE && start) begin
            arith_d = ARITH;
        end
    end

    assign fill = (dir_q == DIR_RIGHT) && arith_q && res_q[WIDTH-1];
`else
    assign fill = 1'b0;
`endif

    shift_step_1bit #(.WIDTH(WIDTH)) u_step (
        .value   (res_q),
        .dir     (dir_q),
        .fill    (fill),
        .shifted (step_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    res_d   = A;
                    cnt_d   = SHAMT;
                    dir_d   = DIR;
                    state_d = (SHAMT != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                res_d = step_out;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Result    = res_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule
